scrambler_sequencer: RTL and testbench

Frame-level controller for the 802.11a transmit scrambler. It accepts a PSDU length and data-rate parameter and computes the OFDM symbol count and pad-bit count. It then sequences the bit stream fed to the scrambler (SERVICE zeros, PSDU bits pulled from the MAC, tail, pad) and forces the 6 scrambled tail bits to zero. It sits between the MAC bit source and the scrambler, and emits the scrambled stream to the convolutional encoder.

---
 rtl/scrambler_sequencer.sv | 164 ++++++++++++++++
 tb/tb_scrambler_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scrambler_sequencer
// Purpose  : 802.11a TX frame controller. Computes Nsym/pad, then feeds the
//            scrambler with SERVICE, PSDU, TAIL and PAD bits in order.
// Revision : 1.0
// ============================================================================
module scrambler_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] length,
    input  logic [7:0]  ndbps,
    output logic        mac_req,
    input  logic        mac_bit,
    input  logic        mac_valid,
    output logic        scr_en,
    output logic        scr_data_in,
    input  logic        scr_data_out,
    output logic        out_bit,
    output logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [10:0] nsym
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_SERVICE = 3'd2,
        S_PSDU    = 3'd3,
        S_TAIL    = 3'd4,
        S_PAD     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [11:0] r_len;
    logic [7:0]  r_ndbps;
    logic [15:0] r_acc;
    logic [10:0] r_nsym;
    logic [7:0]  r_pad;
    logic [14:0] r_cnt;
    logic        r_out_bit;
    logic        r_out_valid;
    logic        r_done;
    logic        r_err;

    logic        w_ndbps_legal;
    logic        w_accept;
    logic        w_req_ok;
    logic        w_underrun;
    logic        w_last_in;
    logic [14:0] w_psdu_bits;
    logic [15:0] w_need;
    logic [15:0] w_acc_sum;

    always_comb begin
        case (ndbps)
            8'd24, 8'd36, 8'd48, 8'd72,
            8'd96, 8'd144, 8'd192, 8'd216: w_ndbps_legal = 1'b1;
            default:                       w_ndbps_legal = 1'b0;
        endcase
    end

    // The Done cycle is already IDLE but still busy, so a Start there is ignored.
    assign w_accept    = (r_state == S_IDLE) && start && !r_out_valid;
    assign w_req_ok    = w_accept && (length != 12'd0) && w_ndbps_legal;
    assign w_psdu_bits = {r_len, 3'b000};
    assign w_need      = {1'b0, w_psdu_bits} + 16'd22;
    assign w_acc_sum   = r_acc + {8'd0, r_ndbps};
    assign w_underrun  = (r_state == S_PSDU) && !mac_valid;

    always_comb begin
        w_state_nx  = r_state;
        scr_en      = 1'b0;
        scr_data_in = 1'b0;
        mac_req     = 1'b0;
        w_last_in   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_ok) w_state_nx = S_CALC;
            end
            S_CALC: begin
                if (w_acc_sum >= w_need) w_state_nx = S_SERVICE;
            end
            S_SERVICE: begin
                scr_en = 1'b1;
                if (r_cnt == 15'd15) w_state_nx = S_PSDU;
            end
            S_PSDU: begin
                scr_en      = 1'b1;
                mac_req     = 1'b1;
                scr_data_in = mac_bit;
                if (!mac_valid)                          w_state_nx = S_IDLE;
                else if (r_cnt == w_psdu_bits - 15'd1)   w_state_nx = S_TAIL;
            end
            S_TAIL: begin
                scr_en = 1'b1;
                if (r_cnt == 15'd5) begin
                    if (r_pad == 8'd0) begin
                        w_state_nx = S_IDLE;
                        w_last_in  = 1'b1;
                    end else begin
                        w_state_nx = S_PAD;
                    end
                end
            end
            S_PAD: begin
                scr_en = 1'b1;
                if (r_cnt == {7'd0, r_pad} - 15'd1) begin
                    w_state_nx = S_IDLE;
                    w_last_in  = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= 12'd0;
            r_ndbps     <= 8'd0;
            r_acc       <= 16'd0;
            r_nsym      <= 11'd0;
            r_pad       <= 8'd0;
            r_cnt       <= 15'd0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= (w_state_nx != r_state) ? 15'd0 : r_cnt + 15'd1;
            r_err       <= (w_accept && !w_req_ok) || w_underrun;
            r_done      <= w_last_in;
            r_out_valid <= scr_en && !w_underrun;
            // Scrambled tail bits are forced to zero so the encoder terminates.
            r_out_bit   <= (scr_en && (r_state != S_TAIL)) ? scr_data_out : 1'b0;
            if (w_req_ok) begin
                r_len   <= length;
                r_ndbps <= ndbps;
                r_acc   <= 16'd0;
                r_nsym  <= 11'd0;
            end
            if (r_state == S_CALC) begin
                r_acc  <= w_acc_sum;
                r_nsym <= r_nsym + 11'd1;
                if (w_acc_sum >= w_need) r_pad <= w_acc_sum[7:0] - w_need[7:0];
            end
        end
    end

    assign out_bit   = r_out_bit;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign nsym      = r_nsym;
    assign busy      = (r_state != S_IDLE) || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_scrambler_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scrambler_sequencer
// Purpose  : Scoreboard bench for scrambler_sequencer with an external
//            x^7+x^4+1 scrambler and a random MAC bit source.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_scrambler_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] length = 12'd0;
    logic [7:0]  ndbps = 8'd0;
    logic        mac_req;
    logic        mac_bit;
    logic        mac_valid = 1'b1;
    logic        scr_en;
    logic        scr_data_in;
    logic        scr_data_out;
    logic        out_bit;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] nsym;

    always #5 clk = ~clk;

    scrambler_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .length       (length),
        .ndbps        (ndbps),
        .mac_req      (mac_req),
        .mac_bit      (mac_bit),
        .mac_valid    (mac_valid),
        .scr_en       (scr_en),
        .scr_data_in  (scr_data_in),
        .scr_data_out (scr_data_out),
        .out_bit      (out_bit),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .nsym         (nsym)
    );

    // External scrambler: lfsr[6]=x7, lfsr[3]=x4; disabled means reload all ones.
    logic [6:0] lfsr = 7'h7f;
    always @(posedge clk) lfsr <= scr_en ? {lfsr[5:0], lfsr[6] ^ lfsr[3]} : 7'h7f;
    assign scr_data_out = scr_data_in ^ lfsr[6] ^ lfsr[3];

    // MAC source: bits consumed in order from a circular memory.
    bit mac_mem [65536];
    int mac_ptr = 0;
    always @(posedge clk) if (mac_req && mac_valid) mac_ptr <= mac_ptr + 1;
    assign mac_bit = mac_mem[mac_ptr % 65536];

    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_q [$];
    bit pn [127];
    int nd_tab [8] = '{24, 36, 48, 72, 96, 144, 192, 216};

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every valid output bit.
    int          ov_total = 0;
    int          ov_base = 0;
    int          done_total = 0;
    int          err_total = 0;
    logic [15:0] first16 = 16'd0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (ov_total - ov_base < 16) first16 = {first16[14:0], out_bit};
                ov_total++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_unexpected: got valid bit %0d expected no output", out_bit);
                end else begin
                    check("out_bit", int'(out_bit), int'(exp_q.pop_front()));
                end
            end
            if (done) begin
                done_total++;
                check("done_on_last_valid", int'(out_valid && exp_q.size() == 0), 1);
            end
            if (err) err_total++;
        end
    end

    // Reference: a frame is Nsym*Ndbps bits of [16 zeros | PSDU | 6 tail | pad],
    // XORed with the 127-periodic scrambler sequence, tail forced to zero.
    task automatic run_frame(input int len, input int nd, input int mode, input bit zero_mac);
        int nbits, ns, total, base, cyc, first_req, reqs, ov0, done0, err0;
        bit finished, aborted, exp_b;
        nbits = 8 * len;
        ns    = (nbits + 22 + nd - 1) / nd;
        total = ns * nd;
        base  = mac_ptr;
        for (int i = 0; i < nbits; i++)
            mac_mem[(base + i) % 65536] = zero_mac ? 1'b0 : 1'($urandom_range(0, 1));
        for (int i = 0; i < total; i++) begin
            if (i >= 16 + nbits && i < 22 + nbits) exp_b = 1'b0;
            else begin
                exp_b = pn[i % 127];
                if (i >= 16 && i < 16 + nbits) exp_b ^= mac_mem[(base + i - 16) % 65536];
            end
            exp_q.push_back(exp_b);
        end
        ov_base = ov_total;
        ov0     = ov_total;
        done0   = done_total;
        err0    = err_total;
        length  = 12'(len);
        ndbps   = 8'(nd);
        start   = 1'b1;
        step();
        start   = 1'b0;
        check("busy_cycle1", int'(busy), 1);
        cyc = 1; first_req = 0; reqs = 0; finished = 0; aborted = 0;
        while (!finished && !aborted && cyc < 40000) begin
            if (start) begin
                start  = 1'b0;
                length = 12'(len);
            end
            if (mac_req) begin
                reqs++;
                if (first_req == 0) first_req = cyc;
            end
            if (done) finished = 1;
            else if (mode == 1 && mac_req && reqs == 10) begin
                mac_valid = 1'b0;
                step();
                mac_valid = 1'b1;
                check("underrun_err", int'(err), 1);
                check("underrun_out_valid", int'(out_valid), 0);
                check("underrun_scr_en", int'(scr_en), 0);
                check("underrun_busy", int'(busy), 0);
                check("underrun_bits_out", ov_total - ov0, 25);
                step();
                check("underrun_err_pulse", int'(err), 0);
                check("underrun_no_done", done_total - done0, 0);
                aborted = 1;
            end else if (mode == 3 && mac_req && reqs == 5) begin
                rst_n = 1'b0;
                #1;
                check("async_reset_outputs",
                      int'({mac_req, scr_en, scr_data_in, out_bit, out_valid, busy, done, err, nsym}), 0);
                step();
                step();
                rst_n = 1'b1;
                aborted = 1;
            end else begin
                if (mode == 2 && reqs == 3) begin
                    start  = 1'b1;
                    length = 12'(len + 7);
                end
                step();
                cyc++;
            end
        end
        if (aborted) exp_q.delete();
        else if (!finished) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout: no done after %0d cycles, expected at %0d", cyc, ns + total + 1);
            exp_q.delete();
        end else begin
            check("done_cycle", cyc, ns + total + 1);
            check("nsym", int'(nsym), ns);
            check("mac_req_first_cycle", first_req, ns + 17);
            check("mac_req_cycles", reqs, nbits);
            check("out_valid_cycles", ov_total - ov0, total);
            check("err_quiet", err_total - err0, 0);
            if (zero_mac) check("first16", int'(first16), int'(16'b0000111011110010));
            step();
            check("busy_after_done", int'(busy), 0);
        end
    endtask

    task automatic illegal(input int len, input int nd);
        length = 12'(len);
        ndbps  = 8'(nd);
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("illegal_err", int'(err), 1);
        check("illegal_busy", int'(busy), 0);
        check("illegal_scr_en", int'(scr_en), 0);
        step();
        check("illegal_err_pulse", int'(err), 0);
        check("illegal_stay_idle", int'(busy || scr_en), 0);
    endtask

    initial begin
        bit f [134];
        for (int j = 0; j < 134; j++) f[j] = (j < 7) ? 1'b1 : (f[j - 7] ^ f[j - 4]);
        for (int i = 0; i < 127; i++) pn[i] = f[i + 7];

        step();
        step();
        check("reset_outputs",
              int'({mac_req, scr_en, scr_data_in, out_bit, out_valid, busy, done, err, nsym}), 0);
        rst_n = 1'b1;
        step();

        run_frame(1, 24, 0, 1);
        run_frame(100, 216, 0, 0);
        illegal(10, 50);
        illegal(0, 24);
        run_frame(20, 48, 1, 0);
        run_frame(1, 24, 0, 1);
        run_frame(30, 36, 2, 0);
        run_frame(5, 72, 0, 0);
        run_frame(3, 96, 0, 0);
        run_frame(2, 144, 0, 1);
        run_frame(40, 192, 3, 0);
        run_frame(7, 24, 0, 0);
        for (int k = 0; k < 5; k++)
            run_frame(int'($urandom_range(1, 200)), nd_tab[$urandom_range(0, 7)], 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
